// File: rtl/mem_miss_ctrl.sv
// Cache miss initiator for the single-ported L2 block interface: optional victim
// writeback, mandatory one-cycle request gap, block fill, stall counter and timeout abort.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a miss; latches the cache request on accept
// S_WB     | victim writeback transaction in flight (mem_we=1)
// S_WB_GAP | one cycle with mem_req low so memory restarts its latency
// S_FILL   | block fill transaction in flight (mem_we=0)
// S_RESP   | fill_valid pulse; fill_addr/fill_block hold the result
// S_ABORT  | mem_err pulse after a transaction stalled too long
module mem_miss_ctrl #(
  parameter int BLOCKS   = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cache_req,
  output logic                 cache_ready,
  input  logic [31:0]          cache_addr,
  input  logic                 cache_wb,
  input  logic [31:0]          cache_wb_addr,
  input  logic [BLOCKS*32-1:0] cache_wb_block,
  output logic                 fill_valid,
  output logic [31:0]          fill_addr,
  output logic [BLOCKS*32-1:0] fill_block,
  output logic                 mem_err,
  output logic [31:0]          stall_cycles,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  output logic                 mem_we,
  output logic [BLOCKS*32-1:0] mem_write_block,
  input  logic [BLOCKS*32-1:0] mem_read_block,
  input  logic                 mem_miss
);

  localparam int          BW         = BLOCKS * 32;
  localparam int          OFFS       = $clog2(BLOCKS * 4);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFS) - 32'd1);
  localparam logic [31:0] MAX_W      = 32'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_WB_GAP, S_FILL, S_RESP, S_ABORT
  } state_t;

  state_t          r_state, w_next;
  logic [31:0]     r_miss_addr, r_wait, r_stall;
  logic            r_mem_req, r_mem_we, r_fill_valid, r_mem_err;
  logic [31:0]     r_mem_addr, r_fill_addr;
  logic [BW-1:0]   r_mem_wblk, r_fill_block;

  logic            w_accept, w_busy, w_timeout;
  logic [31:0]     w_miss_addr, w_mem_addr_nxt;
  logic [BW-1:0]   w_mem_wblk_nxt;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_busy    = (r_state == S_WB) || (r_state == S_FILL);
    w_timeout = (MAX_W != 32'd0) && w_busy && mem_miss && ((r_wait + 32'd1) == MAX_W);
    case (r_state)
      S_IDLE: begin
        if (cache_req) begin
          w_accept = 1'b1;
          w_next   = cache_wb ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (!mem_miss)      w_next = S_WB_GAP;
        else if (w_timeout) w_next = S_ABORT;
      end
      S_WB_GAP: w_next = S_FILL;
      S_FILL: begin
        if (!mem_miss)      w_next = S_RESP;
        else if (w_timeout) w_next = S_ABORT;
      end
      S_RESP:   w_next = S_IDLE;
      S_ABORT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    // Memory-side outputs are registered from the next state so they line up with it.
    w_miss_addr    = w_accept ? (cache_addr & ALIGN_MASK) : r_miss_addr;
    w_mem_addr_nxt = '0;
    w_mem_wblk_nxt = '0;
    if (w_next == S_WB) begin
      w_mem_addr_nxt = w_accept ? (cache_wb_addr & ALIGN_MASK) : r_mem_addr;
      w_mem_wblk_nxt = w_accept ? cache_wb_block : r_mem_wblk;
    end else if (w_next == S_FILL) begin
      w_mem_addr_nxt = w_miss_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_miss_addr  <= '0;
      r_wait       <= '0;
      r_stall      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wblk   <= '0;
      r_fill_valid <= 1'b0;
      r_mem_err    <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_block <= '0;
    end else begin
      r_state      <= w_next;
      r_miss_addr  <= w_miss_addr;
      r_mem_req    <= (w_next == S_WB) || (w_next == S_FILL);
      r_mem_we     <= (w_next == S_WB);
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wblk   <= w_mem_wblk_nxt;
      r_fill_valid <= (w_next == S_RESP);
      r_mem_err    <= (w_next == S_ABORT);
      if (!w_busy)       r_wait <= '0;
      else if (mem_miss) r_wait <= r_wait + 32'd1;
      if (r_mem_req && mem_miss && (r_stall != 32'hFFFF_FFFF))
        r_stall <= r_stall + 32'd1;
      if ((r_state == S_FILL) && !mem_miss) begin
        r_fill_addr  <= r_miss_addr;
        r_fill_block <= mem_read_block;
      end
    end
  end

  assign cache_ready     = (r_state == S_IDLE) & reset;
  assign fill_valid      = r_fill_valid;
  assign fill_addr       = r_fill_addr;
  assign fill_block      = r_fill_block;
  assign mem_err         = r_mem_err;
  assign stall_cycles    = r_stall;
  assign mem_req         = r_mem_req;
  assign mem_addr        = r_mem_addr;
  assign mem_we          = r_mem_we;
  assign mem_write_block = r_mem_wblk;

endmodule

// File: doc/mem_miss_ctrl.md
# mem_miss_ctrl

Cache-side initiator for the single-ported L2 block interface. It accepts one miss at a time from the cache controller: an optional dirty-victim writeback plus a block fill. It sequences these as separate `mem_req` transactions, honours the `mem_miss` stall from the memory side, and returns the filled block to the cache. It also keeps a stall-cycle performance counter and aborts any transaction stalled past a programmable timeout.

## Interface
- `BLOCKS`, default 4: 32-bit words per cache block; a power of 2, at least 1.
- `MAX_WAIT`, default 64: maximum consecutive stalled cycles per transaction; 0 disables the timeout.
- `clock` input 1: single clock, all state updates on its rising edge.
- `reset` input 1: synchronous, active-low.
- `cache_req` input 1: miss request valid.
- `cache_ready` output 1: controller idle and able to accept.
- `cache_addr` input 32: miss address, byte granular.
- `cache_wb` input 1: a writeback of the victim is required.
- `cache_wb_addr` input 32: victim address, byte granular.
- `cache_wb_block` input BLOCKS×32: victim data.
- `fill_valid` output 1: one-cycle pulse, fill data valid.
- `fill_addr` output 32: block-aligned address of the fill.
- `fill_block` output BLOCKS×32: filled data.
- `mem_err` output 1: one-cycle pulse, transaction aborted by timeout.
- `stall_cycles` output 32: saturating count of cycles with `mem_req & mem_miss`.
- `mem_req` output 1: memory transaction request.
- `mem_addr` output 32: block-aligned transaction address.
- `mem_we` output 1: 1 for writeback, 0 for fill.
- `mem_write_block` output BLOCKS×32: writeback data.
- `mem_read_block` input BLOCKS×32: read data, valid in the completion cycle.
- `mem_miss` input 1: memory busy; the transaction is not complete.

## Operation
- States: IDLE, WB, WB_GAP, FILL, RESP, ABORT.
- **Block alignment:** clear the low log2(BLOCKS×4) address bits. With BLOCKS=4 this is `addr & ~32'hF`.
- **IDLE:**
  - `cache_ready` is 1.
  - On `cache_req` the controller latches all cache inputs.
  - Next state is WB if `cache_wb`, otherwise FILL.
- **WB:**
  - Drives `mem_req`=1, `mem_we`=1, `mem_addr`=aligned victim address, `mem_write_block`=victim data.
  - These are held constant until completion.
  - Completion is a cycle with `mem_req`=1 and `mem_miss`=0; the next state is WB_GAP.
- **WB_GAP:**
  - `mem_req`=0 for exactly one cycle. This is mandatory: the memory side resets its latency counter only while `mem_req` is low.
  - Next state is FILL.
- **FILL:**
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=aligned miss address.
  - In the completion cycle the controller latches `mem_read_block` into the fill register; the next state is RESP.
- **RESP:**
  - `mem_req`=0 and `fill_valid`=1 for one cycle.
  - `fill_addr` and `fill_block` are held stable until the next fill.
  - Next state is IDLE.
- **Timeout:**
  - A wait counter clears on entry to WB or FILL and increments on each cycle with `mem_miss`=1.
  - If MAX_WAIT≠0 and the counter reaches MAX_WAIT while `mem_miss`=1, the next state is ABORT.
  - An abort during WB skips the fill.
- **ABORT:**
  - `mem_req`=0 and `mem_err`=1 for one cycle; `fill_valid` stays 0.
  - Next state is IDLE.
- **`stall_cycles`:** increments on each `mem_req & mem_miss` cycle and saturates at 32'hFFFF_FFFF.
- **Idle memory outputs:** whenever `mem_req`=0, `mem_we`=0, `mem_addr`=0 and `mem_write_block`=0.

## Timing
- All outputs are registered except `cache_ready`, which is `(state==IDLE) & reset`.
- **Reset values:** state IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_write_block` = 0; `fill_valid`, `mem_err` = 0; `fill_addr`, `fill_block` = 0; `stall_cycles` = 0; `cache_ready` = 0 while `reset` is low.
- **Accept:** at edge T. `mem_req` rises in cycle T+1.
- **Fill-only latency:** with memory latency L (L stalled cycles, then completion), `fill_valid` asserts L+2 cycles after accept.
- **Fill with writeback:** adds L+2 cycles (writeback transaction plus gap).
- A `cache_req` that arrives while `cache_ready`=0 is ignored. The cache must hold it until it sees `cache_ready`.
- Back-to-back misses: the earliest accept is the cycle after RESP, so `mem_req` is low for at least 2 cycles between fills.
- **Reset mid-transaction:** returns to IDLE at the next edge and drops `mem_req` immediately. No `fill_valid` or `mem_err` is produced.
- **Simultaneous events:** completion in the same cycle the counter would reach MAX_WAIT counts as completion, because `mem_miss`=0 in that cycle.

## Test plan
- **Fill only, L=3:** `cache_addr`=0x0000_1234, `cache_wb`=0, memory returns word i = 0x1230+4i. Required: `mem_addr`=0x0000_1230, `mem_we`=0, `mem_req` high 4 cycles, `fill_valid` 5 cycles after accept, `fill_block`={0x123C,0x1238,0x1234,0x1230}, `stall_cycles`=3.
- **Writeback then fill, L=3:**
  - Stimulus: `cache_wb_addr`=0x0000_0A08, data {4,3,2,1}; `cache_addr`=0x40.
  - Required: a WB transaction to 0xA00 with `mem_we`=1, then exactly one cycle of `mem_req`=0, then a FILL to 0x40.
  - Required: the memory array holds {4,3,2,1} at 0xA00; `fill_valid` at accept+10.
- **Zero latency:** with `mem_miss` tied 0, `mem_req` is high 1 cycle and `fill_valid` asserts at accept+2.
- **Timeout:** MAX_WAIT=8 with `mem_miss` held 1. Required: `mem_req` high 8 cycles, then `mem_err` pulses once, no `fill_valid`, `cache_ready` returns, `stall_cycles`=8.
- **Reset mid-FILL:** pull `reset` low at stall cycle 2. Required: `mem_req`=0 at the next edge, all outputs at reset values, no pulses; after release, a new miss to 0x80 completes normally.
- **Ignored request and back-to-back:** two consecutive misses with `cache_req` held high. The second is accepted only in the cycle after RESP, with no overlap between `mem_req` periods.
